cdb_grant_controller: RTL and testbench
=======================================

Name: cdb_grant_controller

Overview:
- Central grant controller for the two common data buses; the responder side of the per-combo bus arbiters.
- Each execution combo raises a bus request while its unit holds a valid result.
- This block drives each bus's `select` address. The combo whose ARBITER_ADDRESS matches sees bus_granted, drives its result, and advances its reservation station.
- Round-robin fair, registered outputs, at most one requester per bus per cycle.

Parameters:
- N_REQ, 4, number of requesting combos; requester i owns select address i (valid range 1..254).
- IDLE_ADDR, 8'hFF, select value meaning "bus not granted"; no combo may use it.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- request  in  N_REQ  bit i = combo i holds a result and wants a bus.
- bus_ready  in  2  bit b = bus b's consumers (ROB, stations) accept a broadcast next cycle.
- select0  out  8  address granted on data bus 0 (registered).
- select1  out  8  address granted on data bus 1 (registered).
- grant_valid  out  2  bit b = select_b is not IDLE_ADDR (registered).
- grant_vec  out  N_REQ  one-hot-or-zero per requester; OR of both current grants (registered, for debug/perf counters).

Behaviour:
- Reset (asserted low, async): select0 = select1 = IDLE_ADDR, grant_valid = 0, grant_vec = 0, rr_ptr = 0. Outputs hold these values until the first clock edge after reset deassertion.
- Latency: request/bus_ready sampled at edge t; resulting grant appears on select0/select1 from edge t until edge t+1 (one full cycle). Requester drives its result during that cycle.
- Eligibility mask: eligible[i] = request[i] AND NOT grant_vec[i].
  - A requester granted in the current cycle is excluded from the next arbitration, because its request line still reflects the result being broadcast now.
  - Net effect: any single requester gets at most one grant per two cycles.
- Search order: circular from rr_ptr upward, wrapping N_REQ-1 -> 0.
- Slot assignment:
  - first = first eligible index in search order; second = next eligible index after first.
  - Both buses ready: bus0 <- first, bus1 <- second.
  - Only bus0 ready: bus0 <- first, bus1 idle.
  - Only bus1 ready: bus1 <- first, bus0 idle.
  - Neither ready: both idle, rr_ptr unchanged.
- Never grant the same requester on both buses in one cycle. With a single eligible requester, bus0 is preferred (bus1 if only bus1 is ready).
- rr_ptr update:
  - After any grant, rr_ptr <- (index of last granted requester + 1) mod N_REQ.
  - No grant: rr_ptr holds.
  - Use explicit compare for wrap; N_REQ need not be a power of two.
- grant_vec[i] = 1 iff i was granted on either bus this cycle. grant_valid[b] = (select_b != IDLE_ADDR).
- Request dropping while granted is legal: the grant still completes its cycle and the controller does not retract it.
- Reset mid-operation: outputs go idle immediately (async) and rr_ptr returns to 0. Any broadcast in flight is abandoned; combos are reset by the same signal.
- Out-of-range requester addresses never appear. Indices 0..N_REQ-1 map directly to the 8-bit select value, zero-extended.

Test Plan:
- Reset: hold reset=0 with request=4'b1111 -> select0=select1=8'hFF, grant_valid=2'b00. Release reset with bus_ready=2'b11 -> next cycle select0=0, select1=1, grant_vec=4'b0011, rr_ptr=2.
- Round-robin rotation: request=4'b1111, bus_ready=2'b11 held for 4 cycles -> grant pairs (0,1),(2,3),(0,1),(2,3). No requester appears in consecutive cycles.
- Single requester: request=4'b0100 held, bus_ready=2'b11 -> select0=2 on cycles 1,3,5, IDLE_ADDR on 2,4. select1 always 8'hFF.
- Back-pressure: request=4'b0011, bus_ready=2'b10 -> select0=8'hFF, select1=0. Next cycle select1=1. With bus_ready=2'b00 -> both idle and rr_ptr frozen.
- Wrap-around: rr_ptr=3, request=4'b1001, bus_ready=2'b11 -> select0=3, select1=0, rr_ptr=1.
- Async reset mid-grant: assert reset between edges while select0=2 -> select0 goes to 8'hFF immediately, without waiting for a clock edge. After release, arbitration restarts from index 0.

Source files
------------

// File: rtl/cdb_grant_controller.sv
// Round-robin grant controller for the two common data buses.
// Registered select addresses; a requester granted now sits out the next arbitration.
module cdb_grant_controller #(
    parameter int         N_REQ     = 4,
    parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic [1:0]       bus_ready,
    output logic [7:0]       select0,
    output logic [7:0]       select1,
    output logic [1:0]       grant_valid,
    output logic [N_REQ-1:0] grant_vec
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    rr_next;
    logic [N_REQ-1:0] eligible;
    logic [PW-1:0]    first;
    logic [PW-1:0]    second;
    logic             found1;
    logic             found2;
    logic [PW-1:0]    idx;
    logic             g0;
    logic             g1;
    logic [PW-1:0]    g0_idx;
    logic [PW-1:0]    g1_idx;
    logic [PW-1:0]    last;
    logic [7:0]       sel0_next;
    logic [7:0]       sel1_next;
    logic [N_REQ-1:0] gvec_next;

    // Explicit compare keeps the wrap correct for non-power-of-two N_REQ.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (32'(v) == N_REQ - 1)
            return '0;
        else
            return v + 1'b1;
    endfunction

    always_comb begin
        eligible = request & ~grant_vec;
        found1   = 1'b0;
        found2   = 1'b0;
        first    = '0;
        second   = '0;
        idx      = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (eligible[idx]) begin
                if (!found1) begin
                    first  = idx;
                    found1 = 1'b1;
                end else if (!found2) begin
                    second = idx;
                    found2 = 1'b1;
                end
            end
            idx = wrap_inc(idx);
        end
    end

    // A lone ready bus always takes the first eligible requester.
    always_comb begin
        g0     = 1'b0;
        g1     = 1'b0;
        g0_idx = first;
        g1_idx = first;
        last   = first;
        unique case (bus_ready)
            2'b11: begin
                g0     = found1;
                g1     = found2;
                g1_idx = second;
                if (found2)
                    last = second;
            end
            2'b01:   g0 = found1;
            2'b10:   g1 = found1;
            default: ;
        endcase
    end

    always_comb begin
        rr_next   = (g0 || g1) ? wrap_inc(last) : rr_ptr;
        sel0_next = g0 ? 8'(g0_idx) : IDLE_ADDR;
        sel1_next = g1 ? 8'(g1_idx) : IDLE_ADDR;
        gvec_next = '0;
        if (g0)
            gvec_next[g0_idx] = 1'b1;
        if (g1)
            gvec_next[g1_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            select0     <= IDLE_ADDR;
            select1     <= IDLE_ADDR;
            grant_valid <= 2'b00;
            grant_vec   <= '0;
        end else begin
            rr_ptr      <= rr_next;
            select0     <= sel0_next;
            select1     <= sel1_next;
            grant_valid <= {g1, g0};
            grant_vec   <= gvec_next;
        end
    end

endmodule

// File: tb/tb_cdb_grant_controller.sv
// Table-driven bench for cdb_grant_controller with an expectation queue.
// Hand sequences cover reset hold/release and async reset mid-grant.
module tb_cdb_grant_controller;

    localparam logic [7:0] IDLE = 8'hFF;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] request = 4'b0000;
    logic [1:0] bus_ready = 2'b00;
    logic [7:0] select0;
    logic [7:0] select1;
    logic [1:0] grant_valid;
    logic [3:0] grant_vec;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] req;
        logic [1:0] rdy;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [3:0] gv;
    } vec_t;

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [3:0] gv;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[19];

    cdb_grant_controller #(.N_REQ(4), .IDLE_ADDR(8'hFF)) dut (
        .clock      (clock),
        .reset      (reset),
        .request    (request),
        .bus_ready  (bus_ready),
        .select0    (select0),
        .select1    (select1),
        .grant_valid(grant_valid),
        .grant_vec  (grant_vec)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] s0,
                                 input logic [7:0] s1, input logic [3:0] gv);
        logic [1:0] gval;
        gval = {s1 != IDLE, s0 != IDLE};
        chk({tag, ".select0"}, select0, s0);
        chk({tag, ".select1"}, select1, s1);
        chk({tag, ".grant_valid"}, {6'd0, grant_valid}, {6'd0, gval});
        chk({tag, ".grant_vec"}, {4'd0, grant_vec}, {4'd0, gv});
    endtask

    task automatic drive(input logic [3:0] req, input logic [1:0] rdy,
                         input logic [7:0] s0, input logic [7:0] s1,
                         input logic [3:0] gv, input string tag);
        exp_t e;
        request   = req;
        bus_ready = rdy;
        e.s0  = s0;
        e.s1  = s1;
        e.gv  = gv;
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        if (sbq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
        end else begin
            e = sbq.pop_front();
            check_outputs(e.tag, e.s0, e.s1, e.gv);
        end
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 2'b11, 8'h00, 8'h01, 4'b0011};
        vecs[1]  = '{4'b1111, 2'b11, 8'h02, 8'h03, 4'b1100};
        vecs[2]  = '{4'b1111, 2'b11, 8'h00, 8'h01, 4'b0011};
        vecs[3]  = '{4'b1111, 2'b11, 8'h02, 8'h03, 4'b1100};
        vecs[4]  = '{4'b0100, 2'b11, IDLE,  IDLE,  4'b0000};
        vecs[5]  = '{4'b0100, 2'b11, 8'h02, IDLE,  4'b0100};
        vecs[6]  = '{4'b0100, 2'b11, IDLE,  IDLE,  4'b0000};
        vecs[7]  = '{4'b0100, 2'b11, 8'h02, IDLE,  4'b0100};
        vecs[8]  = '{4'b0100, 2'b11, IDLE,  IDLE,  4'b0000};
        vecs[9]  = '{4'b0011, 2'b10, IDLE,  8'h00, 4'b0001};
        vecs[10] = '{4'b0011, 2'b10, IDLE,  8'h01, 4'b0010};
        vecs[11] = '{4'b0011, 2'b00, IDLE,  IDLE,  4'b0000};
        vecs[12] = '{4'b0011, 2'b01, 8'h00, IDLE,  4'b0001};
        vecs[13] = '{4'b0100, 2'b11, 8'h02, IDLE,  4'b0100};
        vecs[14] = '{4'b1001, 2'b11, 8'h03, 8'h00, 4'b1001};
        vecs[15] = '{4'b0000, 2'b11, IDLE,  IDLE,  4'b0000};
        vecs[16] = '{4'b1111, 2'b11, 8'h01, 8'h02, 4'b0110};
        vecs[17] = '{4'b1111, 2'b11, 8'h03, 8'h00, 4'b1001};
        vecs[18] = '{4'b0000, 2'b11, IDLE,  IDLE,  4'b0000};

        reset     = 1'b0;
        request   = 4'b1111;
        bus_ready = 2'b11;
        repeat (3) @(posedge clock);
        #1;
        check_outputs("reset_hold", IDLE, IDLE, 4'b0000);
        reset = 1'b1;
        #1;
        check_outputs("reset_release", IDLE, IDLE, 4'b0000);

        for (int i = 0; i < 19; i++)
            drive(vecs[i].req, vecs[i].rdy, vecs[i].s0, vecs[i].s1,
                  vecs[i].gv, $sformatf("vec%0d", i));

        // rr_ptr is 1 here; a lone requester 2 lands on bus0.
        drive(4'b0100, 2'b11, 8'h02, IDLE, 4'b0100, "pre_async");
        #3;
        reset = 1'b0;
        #1;
        check_outputs("async_reset", IDLE, IDLE, 4'b0000);
        #2;
        reset = 1'b1;
        drive(4'b1111, 2'b11, 8'h00, 8'h01, 4'b0011, "restart");
        drive(4'b1111, 2'b11, 8'h02, 8'h03, 4'b1100, "restart2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
